// File: rtl/sprite_blit_master_pkg.sv
// Shared types and constants for the sprite blit master: FSM states, word geometry
// and the transparent-byte mask helper.
package blit_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [WORD_BYTES-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_e;

    // Byte-enable mask that keeps every byte differing from the transparent key.
    function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [8*WORD_BYTES-1:0] data,
                                                        input logic [7:0]              key);
        logic [WORD_BYTES-1:0] m;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            m[i] = (data[8*i +: 8] != key);
        end
        return m;
    endfunction

endpackage

// File: rtl/sprite_blit_master_if.sv
// Avalon-MM master bus bundle between the blit master and the system interconnect.
interface sprite_blit_master_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] M_ADDR;
    logic              M_READ;
    logic              M_WRITE;
    logic [3:0]        M_BYTE_EN;
    logic [31:0]       M_WRITEDATA;
    logic [31:0]       M_READDATA;
    logic              M_WAITREQUEST;
    logic              M_READDATAVALID;

    modport master (
        output M_ADDR, M_READ, M_WRITE, M_BYTE_EN, M_WRITEDATA,
        input  M_READDATA, M_WAITREQUEST, M_READDATAVALID
    );

    modport slave (
        input  M_ADDR, M_READ, M_WRITE, M_BYTE_EN, M_WRITEDATA,
        output M_READDATA, M_WAITREQUEST, M_READDATAVALID
    );
endinterface

// File: rtl/blit_addr_gen.sv
// Walks the copy rectangle: x/y counters, per-row source/destination bases and the
// addresses the next bus request will use (derived from next-cycle counter values).
module blit_addr_gen
    import blit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] src_stride,
    input  logic [ADDR_W-1:0] dst_stride,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] rd_addr_c,
    output logic [ADDR_W-1:0] wr_addr_c,
    output logic              last_word_c,
    output logic              last_row_c
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d, width_q, width_d, height_q, height_d;
    logic [ADDR_W-1:0] src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [ADDR_W-1:0] src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;

    assign last_word_c = (x_q == DIM_W'(width_q - DIM_W'(1)));
    assign last_row_c  = (y_q == DIM_W'(height_q - DIM_W'(1)));

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        width_d      = width_q;
        height_d     = height_q;
        src_row_d    = src_row_q;
        dst_row_d    = dst_row_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        if (load) begin
            x_d          = '0;
            y_d          = '0;
            width_d      = width;
            height_d     = height;
            src_row_d    = src_base & ALIGN_MASK;
            dst_row_d    = dst_base & ALIGN_MASK;
            src_stride_d = src_stride & ALIGN_MASK;
            dst_stride_d = dst_stride & ALIGN_MASK;
        end else if (advance) begin
            if (last_word_c) begin
                x_d       = '0;
                y_d       = y_q + DIM_W'(1);
                src_row_d = src_row_q + src_stride_q;
                dst_row_d = dst_row_q + dst_stride_q;
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    // Addresses follow the next-cycle position so the registered bus outputs line up.
    assign rd_addr_c = src_row_d + ADDR_W'(x_d) * ADDR_W'(WORD_BYTES);
    assign wr_addr_c = dst_row_d + ADDR_W'(x_d) * ADDR_W'(WORD_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            width_q      <= '0;
            height_q     <= '0;
            src_row_q    <= '0;
            dst_row_q    <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            width_q      <= width_d;
            height_q     <= height_d;
            src_row_q    <= src_row_d;
            dst_row_q    <= dst_row_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
        end
    end

endmodule

// File: rtl/sprite_blit_master.sv
// Avalon-MM blit master copying a strided rectangle of 32-bit words, one read then one write.
// Optional build macro BLIT_TRANSPARENT_EN masks bytes equal to KEY and skips all-key words.
module sprite_blit_master
    import blit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] SRC_BASE,
    input  logic [ADDR_W-1:0] DST_BASE,
    input  logic [ADDR_W-1:0] SRC_STRIDE,
    input  logic [ADDR_W-1:0] DST_STRIDE,
    input  logic [DIM_W-1:0]  WIDTH_WORDS,
    input  logic [DIM_W-1:0]  HEIGHT_ROWS,
    input  logic [7:0]        KEY,
    output logic              BUSY,
    output logic              DONE,
    sprite_blit_master_if.master m_bus
);

    state_e state_q, state_d;

    logic              load_c, advance_c;
    logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
    logic              last_word_c, last_row_c;

    logic              busy_q, busy_d, done_q, done_d;
    logic              m_read_q, m_read_d, m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [3:0]        m_byte_en_q, m_byte_en_d;
    logic [31:0]       m_writedata_q, m_writedata_d;
    logic [31:0]       data_q, data_d;

`ifdef BLIT_TRANSPARENT_EN
    logic [7:0]        key_q, key_d;
`else
    logic              unused_key_c;
    assign unused_key_c = ^KEY;
`endif

    blit_addr_gen #(
        .ADDR_W(ADDR_W),
        .DIM_W (DIM_W)
    ) u_addr_gen (
        .clk        (CLK),
        .rst        (RESET),
        .load       (load_c),
        .advance    (advance_c),
        .src_base   (SRC_BASE),
        .dst_base   (DST_BASE),
        .src_stride (SRC_STRIDE),
        .dst_stride (DST_STRIDE),
        .width      (WIDTH_WORDS),
        .height     (HEIGHT_ROWS),
        .rd_addr_c  (rd_addr_c),
        .wr_addr_c  (wr_addr_c),
        .last_word_c(last_word_c),
        .last_row_c (last_row_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the load/advance strobes for the address walker.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    load_c  = 1'b1;
                    state_d = (WIDTH_WORDS == '0 || HEIGHT_ROWS == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!m_bus.M_WAITREQUEST) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (m_bus.M_READDATAVALID) begin
                    state_d = S_WR_REQ;
`ifdef BLIT_TRANSPARENT_EN
                    if (keep_mask(m_bus.M_READDATA, key_q) == '0) begin
                        advance_c = 1'b1;
                        state_d   = (last_word_c && last_row_c) ? S_DONE : S_RD_REQ;
                    end
`endif
                end
            end
            S_WR_REQ: begin
                if (!m_bus.M_WAITREQUEST) begin
                    advance_c = 1'b1;
                    state_d   = (last_word_c && last_row_c) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        data_d        = data_q;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        m_read_d      = 1'b0;
        m_write_d     = 1'b0;
        m_addr_d      = '0;
        m_byte_en_d   = '0;
        m_writedata_d = '0;
`ifdef BLIT_TRANSPARENT_EN
        key_d         = key_q;
        if (load_c) key_d = KEY;
`endif
        if (state_q == S_RD_WAIT && m_bus.M_READDATAVALID) data_d = m_bus.M_READDATA;
        case (state_d)
            S_RD_REQ: begin
                busy_d      = 1'b1;
                m_read_d    = 1'b1;
                m_addr_d    = rd_addr_c;
                m_byte_en_d = BE_ALL;
            end
            S_RD_WAIT: busy_d = 1'b1;
            S_WR_REQ: begin
                busy_d        = 1'b1;
                m_write_d     = 1'b1;
                m_addr_d      = wr_addr_c;
                m_writedata_d = data_d;
`ifdef BLIT_TRANSPARENT_EN
                m_byte_en_d   = keep_mask(data_d, key_q);
`else
                m_byte_en_d   = BE_ALL;
`endif
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_addr_q      <= '0;
            m_byte_en_q   <= '0;
            m_writedata_q <= '0;
            data_q        <= '0;
`ifdef BLIT_TRANSPARENT_EN
            key_q         <= '0;
`endif
        end else begin
            busy_q        <= busy_d;
            done_q        <= done_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_addr_q      <= m_addr_d;
            m_byte_en_q   <= m_byte_en_d;
            m_writedata_q <= m_writedata_d;
            data_q        <= data_d;
`ifdef BLIT_TRANSPARENT_EN
            key_q         <= key_d;
`endif
        end
    end

    assign BUSY              = busy_q;
    assign DONE              = done_q;
    assign m_bus.M_READ      = m_read_q;
    assign m_bus.M_WRITE     = m_write_q;
    assign m_bus.M_ADDR      = m_addr_q;
    assign m_bus.M_BYTE_EN   = m_byte_en_q;
    assign m_bus.M_WRITEDATA = m_writedata_q;

endmodule

// File: tb/tb_sprite_blit_master.sv
// Randomized bench for sprite_blit_master: stalling memory slave, logged bus traffic and a
// loop-based rectangle-copy reference model.
module tb_sprite_blit_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [31:0] SRC_BASE = '0, DST_BASE = '0, SRC_STRIDE = '0, DST_STRIDE = '0;
    logic [9:0]  WIDTH_WORDS = '0, HEIGHT_ROWS = '0;
    logic [7:0]  KEY = '0;
    logic        BUSY, DONE;

    sprite_blit_master_if #(.ADDR_W(32)) bus ();

    sprite_blit_master #(.ADDR_W(32), .DIM_W(10)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .SRC_BASE   (SRC_BASE),
        .DST_BASE   (DST_BASE),
        .SRC_STRIDE (SRC_STRIDE),
        .DST_STRIDE (DST_STRIDE),
        .WIDTH_WORDS(WIDTH_WORDS),
        .HEIGHT_ROWS(HEIGHT_ROWS),
        .KEY        (KEY),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .m_bus      (bus)
    );

    always #10 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd_log[$];
    wr_t         wr_log[$];
    logic [31:0] mem_ovr[logic [31:0]];
    int          max_stall = 0;
    int          lat_min = 1, lat_max = 1;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h3C5A_0F00;
    endfunction

    // Memory slave: random request stalls, one read in flight with random latency.
    initial begin
        logic [69:0] held;
        bit          in_req;
        int          stall, lat_cnt;
        logic [31:0] lat_addr;
        in_req  = 1'b0;
        stall   = 0;
        lat_cnt = 0;
        lat_addr = '0;
        held    = '0;
        bus.M_WAITREQUEST   = 1'b0;
        bus.M_READDATAVALID = 1'b0;
        bus.M_READDATA      = '0;
        forever begin
            @(negedge CLK);
            bus.M_READDATAVALID = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.M_READDATAVALID = 1'b1;
                    bus.M_READDATA      = mem_word(lat_addr);
                end
            end
            chk("rw_exclusive", 96'(bus.M_READ & bus.M_WRITE), 96'(0));
            if (bus.M_READ || bus.M_WRITE) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    held   = {bus.M_ADDR, bus.M_WRITEDATA, bus.M_BYTE_EN, bus.M_READ, bus.M_WRITE};
                    stall  = $urandom_range(max_stall, 0);
                end else begin
                    chk("stall_stable",
                        96'({bus.M_ADDR, bus.M_WRITEDATA, bus.M_BYTE_EN, bus.M_READ, bus.M_WRITE}),
                        96'(held));
                end
                if (stall > 0) begin
                    bus.M_WAITREQUEST = 1'b1;
                    stall--;
                end else begin
                    bus.M_WAITREQUEST = 1'b0;
                    in_req = 1'b0;
                    if (bus.M_READ) begin
                        rd_log.push_back(bus.M_ADDR);
                        lat_cnt  = $urandom_range(lat_max, lat_min);
                        lat_addr = bus.M_ADDR;
                    end else begin
                        wr_log.push_back('{bus.M_ADDR, bus.M_WRITEDATA, bus.M_BYTE_EN});
                    end
                end
            end else begin
                bus.M_WAITREQUEST = 1'b0;
                in_req = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  96'(BUSY), 96'(0));
        chk({tag, "_done"},  96'(DONE), 96'(0));
        chk({tag, "_read"},  96'(bus.M_READ), 96'(0));
        chk({tag, "_write"}, 96'(bus.M_WRITE), 96'(0));
        chk({tag, "_addr"},  96'(bus.M_ADDR), 96'(0));
        chk({tag, "_be"},    96'(bus.M_BYTE_EN), 96'(0));
        chk({tag, "_wdata"}, 96'(bus.M_WRITEDATA), 96'(0));
    endtask

    // Issue one command and wait for DONE; cycles counts from the START cycle to the DONE cycle.
    task automatic run_cmd(input logic [31:0] src, dst, ss, ds, input int w, h,
                           input logic [7:0] key, input bit glitch, output int cycles);
        int limit;
        bit active;
        limit  = 20 * w * h + 20;
        active = (w != 0) && (h != 0);
        @(negedge CLK);
        rd_log.delete();
        wr_log.delete();
        SRC_BASE = src; DST_BASE = dst; SRC_STRIDE = ss; DST_STRIDE = ds;
        WIDTH_WORDS = 10'(w); HEIGHT_ROWS = 10'(h); KEY = key;
        START = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        cycles = 1;
        chk("busy_rise", 96'(BUSY), 96'(active));
        chk("read_rise", 96'(bus.M_READ), 96'(active));
        while (!DONE && cycles < limit) begin
            if (glitch && cycles == 4) begin
                START = 1'b1;
                SRC_BASE = $urandom; DST_BASE = $urandom;
                SRC_STRIDE = $urandom; DST_STRIDE = $urandom;
                WIDTH_WORDS = 10'($urandom_range(9, 1)); HEIGHT_ROWS = 10'($urandom_range(9, 1));
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            cycles++;
        end
        START = 1'b0;
        chk("done_seen", 96'(DONE), 96'(1));
        @(negedge CLK);
        chk("done_pulse", 96'(DONE), 96'(0));
        chk("busy_after", 96'(BUSY), 96'(0));
    endtask

    // Reference: plain row/column loops over the rectangle with 32-bit wrapping arithmetic.
    task automatic verify(input string tag, input logic [31:0] src, dst, ss, ds,
                          input int w, h, input logic [7:0] key);
        logic [31:0] erd[$];
        wr_t         ewr[$];
        logic [31:0] ra, wa, d;
        logic [3:0]  be;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                ra = (src & ~32'h3) + 32'(y) * (ss & ~32'h3) + 32'(4 * x);
                wa = (dst & ~32'h3) + 32'(y) * (ds & ~32'h3) + 32'(4 * x);
                d  = mem_word(ra);
                be = 4'hF;
`ifdef BLIT_TRANSPARENT_EN
                for (int b = 0; b < 4; b++) if (d[8*b +: 8] == key) be[b] = 1'b0;
`endif
                erd.push_back(ra);
                if (be != 4'h0) ewr.push_back('{wa, d, be});
            end
        end
        if (key == 8'hxx) $display("unreachable");
        chk({tag, "_nrd"}, 96'(rd_log.size()), 96'(erd.size()));
        chk({tag, "_nwr"}, 96'(wr_log.size()), 96'(ewr.size()));
        for (int i = 0; i < erd.size() && i < rd_log.size(); i++)
            chk({tag, "_rdaddr"}, 96'(rd_log[i]), 96'(erd[i]));
        for (int i = 0; i < ewr.size() && i < wr_log.size(); i++)
            chk({tag, "_wr"}, 96'(wr_log[i]), 96'(ewr[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          w, h;
        logic [31:0] s, d, ss, ds;
        logic [7:0]  k;

        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RESET = 1'b0;

        // Directed 2x2, zero-wait slave, latency 1.
        max_stall = 0; lat_min = 1; lat_max = 1;
        run_cmd(32'h1000, 32'h2000, 32'h40, 32'h100, 2, 2, 8'h00, 1'b0, cyc);
        chk("d2x2_latency", 96'(cyc), 96'(1 + 3 * 2 * 2));
        verify("d2x2", 32'h1000, 32'h2000, 32'h40, 32'h100, 2, 2, 8'h00);

        // Same command with stalls and slow reads.
        max_stall = 3; lat_min = 1; lat_max = 4;
        run_cmd(32'h1000, 32'h2000, 32'h40, 32'h100, 2, 2, 8'h00, 1'b0, cyc);
        verify("s2x2", 32'h1000, 32'h2000, 32'h40, 32'h100, 2, 2, 8'h00);

        // Zero-sized command: immediate DONE, no traffic.
        max_stall = 0; lat_min = 1; lat_max = 1;
        run_cmd(32'h1000, 32'h2000, 32'h40, 32'h100, 0, 5, 8'h00, 1'b0, cyc);
        chk("zero_latency", 96'(cyc), 96'(1));
        verify("zero", 32'h1000, 32'h2000, 32'h40, 32'h100, 0, 5, 8'h00);

        // Address wrap at the top of the space, unaligned base/stride bits ignored.
        run_cmd(32'hFFFF_FFFB, 32'hFFFF_FFF6, 32'h0000_0103, 32'h0000_0022, 4, 2, 8'h5A, 1'b0, cyc);
        chk("wrap_latency", 96'(cyc), 96'(1 + 3 * 4 * 2));
        verify("wrap", 32'hFFFF_FFFB, 32'hFFFF_FFF6, 32'h0000_0103, 32'h0000_0022, 4, 2, 8'h5A);

`ifdef BLIT_TRANSPARENT_EN
        mem_ovr[32'h3000] = 32'h1100_2233;
        mem_ovr[32'h3004] = 32'h0000_0000;
        run_cmd(32'h3000, 32'h4000, 32'h0, 32'h0, 2, 1, 8'h00, 1'b0, cyc);
        chk("key_nwr", 96'(wr_log.size()), 96'(1));
        if (wr_log.size() > 0) chk("key_be", 96'(wr_log[0].be), 96'(4'b1011));
        verify("key", 32'h3000, 32'h4000, 32'h0, 32'h0, 2, 1, 8'h00);
`endif

        // START while busy must not disturb the running command.
        max_stall = 2; lat_min = 1; lat_max = 3;
        run_cmd(32'h0800, 32'h9000, 32'h20, 32'h80, 3, 2, 8'h11, 1'b1, cyc);
        verify("glitch", 32'h0800, 32'h9000, 32'h20, 32'h80, 3, 2, 8'h11);

        // Reset right after the first write is accepted; late read data must be ignored.
        max_stall = 0; lat_min = 3; lat_max = 4;
        @(negedge CLK);
        SRC_BASE = 32'h5000; DST_BASE = 32'h6000; SRC_STRIDE = 32'h10; DST_STRIDE = 32'h10;
        WIDTH_WORDS = 10'd3; HEIGHT_ROWS = 10'd2; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (!bus.M_WRITE && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        chk("rst_first_write", 96'(bus.M_WRITE), 96'(1));
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_idle_outputs("midrst");
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        check_idle_outputs("postrst");
        lat_min = 1; lat_max = 1;
        run_cmd(32'h5000, 32'h6000, 32'h10, 32'h10, 3, 2, 8'h00, 1'b0, cyc);
        chk("rerun_latency", 96'(cyc), 96'(1 + 3 * 3 * 2));
        verify("rerun", 32'h5000, 32'h6000, 32'h10, 32'h10, 3, 2, 8'h00);

        // Random commands against random slave timing.
        for (int t = 0; t < 10; t++) begin
            max_stall = $urandom_range(3, 0);
            lat_min   = 1;
            lat_max   = $urandom_range(4, 1);
            w  = $urandom_range(6, 0);
            h  = $urandom_range(4, 0);
            s  = $urandom; d  = $urandom;
            ss = $urandom_range(32'h400, 0); ds = $urandom;
            k  = 8'($urandom);
            run_cmd(s, d, ss, ds, w, h, k, t[0], cyc);
            verify("rand", s, d, ss, ds, w, h, k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
